alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one external ALU datapath between NUM_REQ requesters. The ALU is the 32-bit unit with A/B inputs, 3-bit ALU_Op, ALU_Out result and Zero flag.
- Each requester presents a valid/ready request carrying operands and an opcode. The block grants one request at a time, sequences it through the ALU and returns a tagged response on a single valid/ready response channel.
- Sits between the issue logic and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Req_Valid  input  NUM_REQ  per-requester request valid.
- Req_Ready  output  NUM_REQ  per-requester grant/accept; one-hot or zero.
- Req_A  input  NUM_REQ x 32  per-requester operand A.
- Req_B  input  NUM_REQ x 32  per-requester operand B.
- Req_Op  input  NUM_REQ x 3  per-requester ALU_Op encoding.
- Alu_A  output  32  operand A driven to the shared ALU.
- Alu_B  output  32  operand B driven to the shared ALU.
- Alu_Op  output  3  opcode driven to the shared ALU.
- Alu_Out  input  32  result from the shared ALU.
- Alu_Zero  input  1  Zero flag from the shared ALU.
- Rsp_Valid  output  1  response valid.
- Rsp_Ready  input  1  response accept from the consumer.
- Rsp_Id  output  ID_W  index of the requester that owns the response.
- Rsp_Data  output  32  captured ALU result.
- Rsp_Zero  output  1  captured Zero flag.
- Busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, rst_n=0):
  - state=IDLE.
  - Alu_A=0, Alu_B=0, Alu_Op=3'b000.
  - Rsp_Valid=0, Rsp_Id=0, Rsp_Data=0, Rsp_Zero=0, Busy=0.
  - Arbitration pointer set so requester 0 has highest priority.
  - Reset mid-operation discards the in-flight op; Rsp_Valid falls immediately (asynchronously).
- IDLE:
  - Req_Ready is combinational: one-hot on the granted index when any Req_Valid is high, else 0. Req_Ready is 0 in all other states.
  - On a grant: capture Req_A/B/Op[g] into the Alu_A/B/Op registers and g into the Id register, then go to EXEC.
- EXEC:
  - Alu_A/B/Op are stable from registers; the ALU is purely combinational.
  - Capture Alu_Out into Rsp_Data and Alu_Zero into Rsp_Zero, then go to RESP.
- RESP:
  - Rsp_Valid=1.
  - Rsp_Id/Data/Zero are held stable until Rsp_Ready=1.
  - On handshake go to IDLE. There is no same-cycle regrant.
- Timing:
  - Latency: accept at edge t gives Rsp_Valid high in cycle t+2, assuming Rsp_Ready=1.
  - Peak throughput is one op per 3 cycles.
- Alu_A/B/Op keep the last granted values between ops; they are not cleared on completion.
- Requesters hold Req_A/B/Op stable while Req_Valid=1 and Req_Ready=0. A requester may withdraw Req_Valid before grant; the arbiter samples only in IDLE.
- Simultaneous Req_Valid from several requesters: exactly one grant per policy below.
- All-zero Req_Valid in IDLE: remain in IDLE, Req_Ready=0.

Optional Feature:
- Macro ALU_ARB_RR_EN.
- Defined (round-robin):
  - The search starts at (last_grant+1) mod NUM_REQ.
  - last_grant updates only on an accepted grant.
  - Reset last_grant=NUM_REQ-1, so requester 0 wins first.
- Undefined (fixed priority):
  - The lowest index wins.
  - The pointer register is not implemented.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE, EXEC, RESP).
  - DATA_W=32, OP_W=3.
  - Opcode localparams OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=3, OP_XOR=4, OP_NOR=5, OP_LSL=6, OP_LSR=7.
- Sub-module rr_arbiter (NUM_REQ; inputs req, advance; output one-hot grant). Contains the pointer logic under ALU_ARB_RR_EN and the fixed-priority logic otherwise.

Test Plan:
- Req 0 only, ADD A=5 B=7, Rsp_Ready=1 -> Req_Ready=4'b0001 at t; Rsp_Valid at t+2 with Data=12, Zero=0, Id=0; Busy high for 2 cycles.
- Req 2 SUB A=9 B=9 -> Rsp_Data=0, Rsp_Zero=1, Rsp_Id=2.
- All four Req_Valid held high, Rsp_Ready=1 -> grant order:
  - with ALU_ARB_RR_EN: 0,1,2,3,0.
  - without: 0,0,0.
- Rsp_Ready low for 5 cycles in RESP -> Rsp_Id/Data/Zero unchanged; Req_Ready=0 throughout; IDLE follows the handshake.
- rst_n pulsed low during EXEC -> Rsp_Valid=0, Busy=0 immediately; after release with all requests valid, the first grant goes to requester 0.
- Req 1 LSL A=1 B=33 (ALU attached) -> Rsp_Data=2, Zero=0; then LSR A=1 B=1 -> Rsp_Data=0, Zero=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// ALU_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
package alu_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR = 3'd5;
  localparam logic [OP_W-1:0] OP_LSL = 3'd6;
  localparam logic [OP_W-1:0] OP_LSR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Request arbiter producing a one-hot grant.
// ALU_ARB_RR_EN: round-robin from last_grant+1; otherwise lowest index wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef ALU_ARB_RR_EN
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_last;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Search upward from the requester after the last winner, wrapping.
  always_comb begin : p_search
    int unsigned c;
    c       = 0;
    grant   = '0;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      c = (32'(r_last) + k) % NUM_REQ;
      if (!w_found && req[PTR_W'(c)]) begin
        grant[PTR_W'(c)] = 1'b1;
        w_idx            = PTR_W'(c);
        w_found          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PTR_W'(NUM_REQ - 1);
    end else if (advance && w_found) begin
      r_last <= w_idx;
    end
  end
`else
  logic w_found;
  logic w_unused;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i]) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_unused = advance ^ clk ^ rst_n;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ valid/ready requesters.
// Arbitration policy selected by ALU_ARB_RR_EN (see rr_arbiter).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  output logic [NUM_REQ-1:0]        Req_Ready,
  input  logic [NUM_REQ*DATA_W-1:0] Req_A,
  input  logic [NUM_REQ*DATA_W-1:0] Req_B,
  input  logic [NUM_REQ*OP_W-1:0]   Req_Op,
  output logic [DATA_W-1:0]         Alu_A,
  output logic [DATA_W-1:0]         Alu_B,
  output logic [OP_W-1:0]           Alu_Op,
  input  logic [DATA_W-1:0]         Alu_Out,
  input  logic                      Alu_Zero,
  output logic                      Rsp_Valid,
  input  logic                      Rsp_Ready,
  output logic [ID_W-1:0]           Rsp_Id,
  output logic [DATA_W-1:0]         Rsp_Data,
  output logic                      Rsp_Zero,
  output logic                      Busy
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic                r_zero;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_advance;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [OP_W-1:0]     w_sel_op;
  logic [ID_W-1:0]     w_sel_id;

  assign w_advance = (r_state == IDLE) && (|Req_Valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (Req_Valid),
    .advance (w_advance),
    .grant   (w_grant)
  );

  // Operand/opcode mux driven by the one-hot grant.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    w_sel_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a  = Req_A[i*DATA_W +: DATA_W];
        w_sel_b  = Req_B[i*DATA_W +: DATA_W];
        w_sel_op = Req_Op[i*OP_W +: OP_W];
        w_sel_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_id     <= '0;
      r_data   <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_advance) begin
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            r_id     <= w_sel_id;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_data  <= Alu_Out;
          r_zero  <= Alu_Zero;
          r_state <= RESP;
        end
        RESP: begin
          if (Rsp_Ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grant is only offered from IDLE; the response phase never regrants.
  assign Req_Ready = (r_state == IDLE) ? w_grant : '0;
  assign Alu_A     = r_alu_a;
  assign Alu_B     = r_alu_b;
  assign Alu_Op    = r_alu_op;
  assign Rsp_Valid = (r_state == RESP);
  assign Rsp_Id    = r_id;
  assign Rsp_Data  = r_data;
  assign Rsp_Zero  = r_zero;
  assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an attached behavioural ALU.
// Expected grants come from a policy model honouring ALU_ARB_RR_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  Req_Valid;
  logic [N-1:0]  Req_Ready;
  logic [N*32-1:0] Req_A;
  logic [N*32-1:0] Req_B;
  logic [N*3-1:0]  Req_Op;
  logic [31:0]   Alu_A;
  logic [31:0]   Alu_B;
  logic [2:0]    Alu_Op;
  logic [31:0]   Alu_Out;
  logic          Alu_Zero;
  logic          Rsp_Valid;
  logic          Rsp_Ready;
  logic [1:0]    Rsp_Id;
  logic [31:0]   Rsp_Data;
  logic          Rsp_Zero;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = N - 1;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [2:0]  op_c [N];

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_A(Req_A), .Req_B(Req_B), .Req_Op(Req_Op),
    .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_Op(Alu_Op),
    .Alu_Out(Alu_Out), .Alu_Zero(Alu_Zero),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
    .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data), .Rsp_Zero(Rsp_Zero),
    .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_LSL:  return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // The shared ALU hanging off the arbiter.
  always_comb begin
    Alu_Out  = alu_f(Alu_A, Alu_B, Alu_Op);
    Alu_Zero = (Alu_Out == 32'd0);
  end

  // Policy model: who should win among the requesters in mask.
  function automatic int exp_winner(input logic [N-1:0] mask);
`ifdef ALU_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (mask[(m_last + k) % N]) return (m_last + k) % N;
    end
`else
    for (int c = 0; c < N; c++) begin
      if (mask[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] one;
    one = 1;
    return (w < 0) ? '0 : (one << w);
  endfunction

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      Req_A[i*32 +: 32] = op_a[i];
      Req_B[i*32 +: 32] = op_b[i];
      Req_Op[i*3 +: 3]  = op_c[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = $urandom;
      op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : $urandom;
      op_c[i] = 3'($urandom_range(0, 7));
    end
    load_ops();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output bit timed_out);
    int c;
    c = 0;
    while (!Rsp_Valid && c < 10) begin
      step();
      c++;
    end
    timed_out = !Rsp_Valid;
  endtask

  // Present one request, return the Req_Ready seen, then advance to RESP.
  task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output logic [N-1:0] rdy, output bit to);
    op_a[r] = a; op_b[r] = b; op_c[r] = op;
    load_ops();
    Req_Valid = onehot(r);
    #1;
    rdy = Req_Ready;
    step();
    Req_Valid = '0;
    wait_rsp(to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Req_Valid = '0; Rsp_Ready = 1'b1;
    Req_A = '0; Req_B = '0; Req_Op = '0;
    repeat (3) step();
    n_checks++;
    if ({Busy, Rsp_Valid, Req_Ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got busy/valid/ready=%b exp 0", {Busy, Rsp_Valid, Req_Ready});
    end
    n_checks++;
    if ({Alu_A, Alu_B, Alu_Op} !== 67'd0) begin
      n_fail++; $display("FAIL reset_alu got A=%h B=%h Op=%h exp 0", Alu_A, Alu_B, Alu_Op);
    end
    n_checks++;
    if ({Rsp_Id, Rsp_Data, Rsp_Zero} !== 35'd0) begin
      n_fail++; $display("FAIL reset_rsp got id=%0d data=%h z=%b exp 0", Rsp_Id, Rsp_Data, Rsp_Zero);
    end
    rst_n = 1'b1;
    m_last = N - 1;
    repeat (3) step();
    n_checks++;
    if ({Busy, Req_Ready} !== 5'b0) begin
      n_fail++; $display("FAIL idle_no_req got busy/ready=%b exp 0", {Busy, Req_Ready});
    end
  endtask

  task automatic test_single_add();
    op_a[0] = 32'd5; op_b[0] = 32'd7; op_c[0] = OP_ADD;
    load_ops();
    Rsp_Ready = 1'b1;
    Req_Valid = 4'b0001;
    #1;
    n_checks++;
    if (Req_Ready !== 4'b0001) begin
      n_fail++; $display("FAIL add_ready got %b exp 0001", Req_Ready);
    end
    m_last = 0;
    step();
    Req_Valid = '0;
    n_checks++;
    if ({Busy, Rsp_Valid, Req_Ready} !== 6'b100000) begin
      n_fail++; $display("FAIL add_exec got busy/valid/ready=%b exp 100000", {Busy, Rsp_Valid, Req_Ready});
    end
    step();
    n_checks++;
    if ({Busy, Rsp_Valid, Rsp_Id, Rsp_Data, Rsp_Zero} !== {1'b1, 1'b1, 2'd0, 32'd12, 1'b0}) begin
      n_fail++; $display("FAIL add_rsp got busy=%b v=%b id=%0d data=%0d z=%b exp 1 1 0 12 0",
                         Busy, Rsp_Valid, Rsp_Id, Rsp_Data, Rsp_Zero);
    end
    step();
    n_checks++;
    if ({Busy, Rsp_Valid} !== 2'b00) begin
      n_fail++; $display("FAIL add_done got busy/valid=%b exp 00", {Busy, Rsp_Valid});
    end
  endtask

  task automatic test_sub_zero();
    logic [N-1:0] rdy;
    bit to;
    run_one(2, 32'd9, 32'd9, OP_SUB, rdy, to);
    m_last = 2;
    n_checks++;
    if (rdy !== 4'b0100 || to) begin
      n_fail++; $display("FAIL sub_grant got ready=%b timeout=%b exp 0100 0", rdy, to);
    end
    n_checks++;
    if ({Rsp_Id, Rsp_Data, Rsp_Zero} !== {2'd2, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL sub_rsp got id=%0d data=%0d z=%b exp 2 0 1", Rsp_Id, Rsp_Data, Rsp_Zero);
    end
    step();
  endtask

  task automatic test_all_valid();
    bit to;
    int w;
    rand_ops();
    Rsp_Ready = 1'b1;
    Req_Valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = exp_winner(4'hF);
      n_checks++;
      if (Req_Ready !== onehot(w)) begin
        n_fail++; $display("FAIL all_grant_%0d got %b exp %b", g, Req_Ready, onehot(w));
      end
      m_last = w;
      step();
      wait_rsp(to);
      n_checks++;
      if (to || Rsp_Id !== 2'(w) || Rsp_Data !== alu_f(op_a[w], op_b[w], op_c[w])) begin
        n_fail++; $display("FAIL all_rsp_%0d got to=%b id=%0d data=%h exp id=%0d data=%h", g, to,
                           Rsp_Id, Rsp_Data, w, alu_f(op_a[w], op_b[w], op_c[w]));
      end
      step();
    end
    Req_Valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy, others;
    logic [31:0] ed;
    bit to;
    int r;
    r = $urandom_range(0, N - 1);
    Rsp_Ready = 1'b0;
    run_one(r, $urandom, $urandom, 3'($urandom_range(0, 7)), rdy, to);
    n_checks++;
    if (rdy !== onehot(exp_winner(onehot(r))) || to) begin
      n_fail++; $display("FAIL bp_grant got ready=%b to=%b exp %b", rdy, to, onehot(r));
    end
    m_last = r;
    ed = alu_f(op_a[r], op_b[r], op_c[r]);
    others = ~onehot(r);
    Req_Valid = others;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({Rsp_Valid, Rsp_Id, Rsp_Data, Rsp_Zero, Req_Ready} !== {1'b1, 2'(r), ed, ed == 0, 4'b0}) begin
        n_fail++; $display("FAIL bp_hold_%0d got v=%b id=%0d data=%h z=%b rdy=%b exp 1 %0d %h %b 0000",
                           c, Rsp_Valid, Rsp_Id, Rsp_Data, Rsp_Zero, Req_Ready, r, ed, ed == 0);
      end
    end
    Rsp_Ready = 1'b1;
    step();
    n_checks++;
    if ({Busy, Rsp_Valid, Req_Ready} !== {2'b00, onehot(exp_winner(others))}) begin
      n_fail++; $display("FAIL bp_idle got busy/valid/ready=%b exp 00%b", {Busy, Rsp_Valid, Req_Ready},
                         onehot(exp_winner(others)));
    end
    Req_Valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bit to;
    rand_ops();
    Rsp_Ready = 1'b1;
    Req_Valid = 4'b1000;
    #1;
    step();
    Req_Valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Busy, Rsp_Valid, Alu_A} !== 34'd0) begin
      n_fail++; $display("FAIL rst_exec got busy=%b v=%b A=%h exp 0", Busy, Rsp_Valid, Alu_A);
    end
    step();
    rst_n = 1'b1;
    m_last = N - 1;
    Rsp_Ready = 1'b0;
    run_one(1, 32'd3, 32'd4, OP_OR, Req_Ready, to);
    m_last = 1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({Busy, Rsp_Valid, Rsp_Data} !== 34'd0) begin
      n_fail++; $display("FAIL rst_resp got busy=%b v=%b data=%h exp 0", Busy, Rsp_Valid, Rsp_Data);
    end
    step();
    rst_n = 1'b1;
    m_last = N - 1;
    Rsp_Ready = 1'b1;
    rand_ops();
    Req_Valid = 4'hF;
    #1;
    n_checks++;
    if (Req_Ready !== 4'b0001) begin
      n_fail++; $display("FAIL rst_first_grant got %b exp 0001", Req_Ready);
    end
    m_last = 0;
    step();
    Req_Valid = '0;
    wait_rsp(to);
    n_checks++;
    if (to || Rsp_Id !== 2'd0 || Rsp_Data !== alu_f(op_a[0], op_b[0], op_c[0])) begin
      n_fail++; $display("FAIL rst_first_rsp got to=%b id=%0d data=%h", to, Rsp_Id, Rsp_Data);
    end
    step();
  endtask

  task automatic test_shift();
    logic [N-1:0] rdy;
    bit to;
    Rsp_Ready = 1'b1;
    run_one(1, 32'd1, 32'd33, OP_LSL, rdy, to);
    m_last = 1;
    n_checks++;
    if (to || {Rsp_Id, Rsp_Data, Rsp_Zero} !== {2'd1, 32'd2, 1'b0}) begin
      n_fail++; $display("FAIL lsl_rsp got to=%b id=%0d data=%0d z=%b exp 1 2 0", to, Rsp_Id, Rsp_Data, Rsp_Zero);
    end
    step();
    run_one(1, 32'd1, 32'd1, OP_LSR, rdy, to);
    n_checks++;
    if (to || {Rsp_Id, Rsp_Data, Rsp_Zero} !== {2'd1, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL lsr_rsp got to=%b id=%0d data=%0d z=%b exp 1 0 1", to, Rsp_Id, Rsp_Data, Rsp_Zero);
    end
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [31:0] ed;
    bit to;
    int w;
    for (int it = 0; it < 25; it++) begin
      rand_ops();
      mask = 4'($urandom_range(1, 15));
      Rsp_Ready = 1'b0;
      Req_Valid = mask;
      #1;
      w = exp_winner(mask);
      n_checks++;
      if (Req_Ready !== onehot(w)) begin
        n_fail++; $display("FAIL rnd_grant_%0d mask=%b got %b exp %b", it, mask, Req_Ready, onehot(w));
      end
      m_last = w;
      step();
      Req_Valid = '0;
      wait_rsp(to);
      ed = alu_f(op_a[w], op_b[w], op_c[w]);
      n_checks++;
      if (to || {Rsp_Id, Rsp_Data, Rsp_Zero} !== {2'(w), ed, ed == 0}) begin
        n_fail++; $display("FAIL rnd_rsp_%0d got to=%b id=%0d data=%h z=%b exp %0d %h %b",
                           it, to, Rsp_Id, Rsp_Data, Rsp_Zero, w, ed, ed == 0);
      end
      repeat ($urandom_range(0, 3)) step();
      Rsp_Ready = 1'b1;
      step();
      n_checks++;
      if ({Busy, Alu_A, Alu_B, Alu_Op} !== {1'b0, op_a[w], op_b[w], op_c[w]}) begin
        n_fail++; $display("FAIL rnd_keep_%0d got busy=%b A=%h B=%h Op=%0d exp 0 %h %h %0d",
                           it, Busy, Alu_A, Alu_B, Alu_Op, op_a[w], op_b[w], op_c[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_zero();
    test_all_valid();
    test_backpressure();
    test_reset_mid();
    test_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
